maxpool_stream_rx: RTL and testbench

- Streaming receiver for one channel-plane of the ReLU'd convolution output.
- Input is a 16-bit signed pixel stream in raster order with a valid/ready handshake. It performs 3x3, stride-2 max pooling, e.g. 27x27 -> 13x13.
- Sits between the conv/ReLU datapath and the normalisation/next-layer buffer. It is the consumer end of the conv output interface.
- One instance is used per channel stream; the channel loop is handled outside this block.

---
 rtl/pool_pkg.sv | 24 ++
 rtl/pool_line_buf.sv | 46 ++++
 rtl/maxpool_stream_rx.sv | 119 +++++++++++
 tb/tb_maxpool_stream_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared parameters, types and the signed max helper for the 3x3 / stride-2
// max-pooling receiver.
package pool_pkg;
  localparam int DATA_W = 16;
  localparam int IMG_W  = 27;
  localparam int IMG_H  = 27;
  localparam int POOL_K = 3;
  localparam int STRIDE = 2;
  localparam int OUT_W  = (IMG_W - POOL_K) / STRIDE + 1;
  localparam int OUT_H  = (IMG_H - POOL_K) / STRIDE + 1;

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int OIDX_W = $clog2((OUT_W > OUT_H) ? OUT_W : OUT_H);

  typedef logic signed [DATA_W-1:0] pix_t;
  typedef logic [COL_W-1:0]         col_t;
  typedef logic [ROW_W-1:0]         row_t;
  typedef logic [OIDX_W-1:0]        oidx_t;

  function automatic pix_t pix_max(pix_t a, pix_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// Per-output-column partial maxima for one pooling row; combinational read
// returns the pre-write value when read and write hit the same entry.
module pool_line_buf
  import pool_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  oidx_t rd_idx,
  output pix_t  rd_data,
  output logic  rd_valid,
  input  logic  wr_en,
  input  oidx_t wr_idx,
  input  pix_t  wr_data
);
  pix_t             mem_data [OUT_W];
  logic [OUT_W-1:0] mem_vld;

  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_entry
      pix_t data_reg;
      logic vld_reg;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          vld_reg <= 1'b0;
        end else if (wr_en && (wr_idx == oidx_t'(gi))) begin
          vld_reg  <= 1'b1;
          data_reg <= wr_data;
        end
      end

      assign mem_data[gi] = data_reg;
      assign mem_vld[gi]  = vld_reg;
    end
  endgenerate

  always_comb begin
    rd_data  = '0;
    rd_valid = 1'b0;
    if (rd_idx < oidx_t'(OUT_W)) begin
      rd_data  = mem_data[rd_idx];
      rd_valid = mem_vld[rd_idx];
    end
  end
endmodule

// File: rtl/maxpool_stream_rx.sv
// Streaming 3x3 stride-2 max pool over a raster-order pixel plane with a
// single registered output stage and plane-length checking.
module maxpool_stream_rx
  import pool_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     frame_err
);
  row_t row_reg;
  col_t col_reg;
  pix_t h_acc_reg;
  logic out_valid_reg, out_last_reg, frame_err_reg;
  pix_t out_data_reg;

  logic  fire, at_end, early_last, missing_last, h_done, row_ok, hv_step;
  logic  cur_wr_en, ovl_wr_en, win_done, last_win;
  logic  cur_rd_valid, ovl_rd_valid;
  pix_t  h_val, cur_rd, ovl_rd, cur_wr_data, win_max;
  oidx_t j_idx, i_idx;

  assign in_ready = !out_valid_reg || out_ready;

  always_comb begin
    fire         = in_valid && in_ready;
    at_end       = (row_reg == row_t'(IMG_H-1)) && (col_reg == col_t'(IMG_W-1));
    early_last   = fire && in_last && !at_end;
    missing_last = fire && !in_last && at_end;
    h_val        = pix_max(h_acc_reg, in_data);
    // Even column >= 2 closes a horizontal 3-wide span; later columns are dropped.
    h_done       = !col_reg[0] && (col_reg >= col_t'(2)) && (col_reg <= col_t'(2*OUT_W));
    row_ok       = row_reg <= row_t'(2*OUT_H);
    j_idx        = oidx_t'((col_reg >> 1) - col_t'(1));
    i_idx        = oidx_t'((row_reg >> 1) - row_t'(1));
    hv_step      = fire && h_done && row_ok && !early_last;
    // Odd rows fold into the window row; even rows close a window and seed the overlap row.
    cur_wr_en    = hv_step && row_reg[0];
    cur_wr_data  = ovl_rd_valid ? pix_max(ovl_rd, h_val) : h_val;
    ovl_wr_en    = hv_step && !row_reg[0];
    win_done     = ovl_wr_en && (row_reg >= row_t'(2)) && cur_rd_valid;
    win_max      = pix_max(cur_rd, h_val);
    last_win     = (i_idx == oidx_t'(OUT_H-1)) && (j_idx == oidx_t'(OUT_W-1));
  end

  pool_line_buf u_cur_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (early_last),
    .rd_idx   (j_idx),
    .rd_data  (cur_rd),
    .rd_valid (cur_rd_valid),
    .wr_en    (cur_wr_en),
    .wr_idx   (j_idx),
    .wr_data  (cur_wr_data)
  );

  pool_line_buf u_ovl_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (early_last),
    .rd_idx   (j_idx),
    .rd_data  (ovl_rd),
    .rd_valid (ovl_rd_valid),
    .wr_en    (ovl_wr_en),
    .wr_idx   (j_idx),
    .wr_data  (h_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg   <= '0;
      col_reg   <= '0;
      h_acc_reg <= '0;
    end else if (fire) begin
      h_acc_reg <= col_reg[0] ? h_val : in_data;
      if (early_last) begin
        row_reg <= '0;
        col_reg <= '0;
      end else if (col_reg == col_t'(IMG_W-1)) begin
        col_reg <= '0;
        row_reg <= at_end ? row_t'(0) : row_reg + row_t'(1);
      end else begin
        col_reg <= col_reg + col_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (early_last || missing_last) frame_err_reg <= 1'b1;
      if (win_done) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= win_max;
        out_last_reg  <= last_win;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign frame_err = frame_err_reg;
endmodule

// File: tb/tb_maxpool_stream_rx.sv
// Directed bench for maxpool_stream_rx: ramp, signed, stalled, truncated,
// reset mid-plane, back-to-back and missing-last planes.
module tb_maxpool_stream_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic out_valid, out_ready = 1'b1, out_last, frame_err;
  logic signed [15:0] in_data = '0, out_data;

  always #5 clk = ~clk;

  maxpool_stream_rx dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pat = 0;
  bit stall_mode = 1'b0;
  bit stall_prev = 1'b0;
  logic signed [15:0] data_prev;
  logic last_prev;
  int q_data[$];
  bit q_last[$];
  int q_cyc[$];

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output-side observer and out_ready driver.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(data_prev));
        check("hold_last", 32'(out_last), 32'(last_prev));
      end
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 0);
    end
    out_ready = stall_mode ? (pat % 4 == 0) : 1'b1;
    pat++;
    stall_prev = !rst && out_valid && !out_ready;
    data_prev  = out_data;
    last_prev  = out_last;
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(int'(out_data));
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
  end

  function automatic int pix(int mode, int base, int r, int c);
    if (mode == 0) return base + r * 27 + c;
    return (r == 4 && c == 6) ? -1 : -5;
  endfunction

  function automatic int exp_win(int mode, int base, int i, int j);
    if (mode == 0) return base + (2*i + 2) * 27 + 2*j + 2;
    return (2*i <= 4 && 4 <= 2*i + 2 && 2*j <= 6 && 6 <= 2*j + 2) ? -1 : -5;
  endfunction

  task automatic send_plane(int mode, int base, int n_pix, int last_at);
    int t;
    bit acc;
    for (int k = 0; k < n_pix; k++) begin
      t = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'(pix(mode, base, k / 27, k % 27));
        in_last  = (k == last_at);
        #2;
        acc = in_ready;
        @(posedge clk);
        t++;
        if (!acc && t > 50) begin
          check("accept_timeout", 0, 1);
          return;
        end
      end
    end
  endtask

  task automatic idle(int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_plane(string tag, int mode, int base, int off, int exp_n, int last_idx);
    int lim;
    lim = q_data.size() - off;
    if (lim > exp_n) lim = exp_n;
    for (int k = 0; k < lim; k++) begin
      check({tag, "_data"}, q_data[off+k], exp_win(mode, base, k / 13, k % 13));
      check({tag, "_last"}, 32'(q_last[off+k]), (k == last_idx) ? 1 : 0);
    end
    $display("plane %s: %0d outputs checked", tag, lim);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_in_ready", 32'(in_ready), 1);

    // Ramp plane, out_ready held high
    send_plane(0, 0, 729, 728);
    idle(20);
    check("ramp_count", q_data.size(), 169);
    check("ramp_first", q_data[0], 56);
    check("ramp_final", q_data[168], 728);
    check_plane("ramp", 0, 0, 0, 169, 168);
    check("ramp_frame_err", 32'(frame_err), 0);

    // Negative plane with one -1 pixel at (4,6)
    q_data.delete(); q_last.delete(); q_cyc.delete();
    send_plane(1, 0, 729, 728);
    idle(20);
    check("neg_count", q_data.size(), 169);
    check_plane("neg", 1, 0, 0, 169, 168);

    // Ramp plane with out_ready 1 on / 3 off
    q_data.delete(); q_last.delete(); q_cyc.delete();
    stall_mode = 1'b1;
    send_plane(0, 0, 729, 728);
    idle(30);
    stall_mode = 1'b0;
    idle(2);
    check("stall_count", q_data.size(), 169);
    check_plane("stall", 0, 0, 0, 169, 168);

    // Early in_last at (10,26): truncated window (4,12) suppressed
    q_data.delete(); q_last.delete(); q_cyc.delete();
    send_plane(0, 0, 297, 296);
    @(negedge clk);
    #2;
    check("early_frame_err", 32'(frame_err), 1);
    idle(20);
    check("early_count", q_data.size(), 64);
    check_plane("early", 0, 0, 0, 64, -1);
    q_data.delete(); q_last.delete(); q_cyc.delete();
    send_plane(0, 0, 729, 728);
    idle(20);
    check("after_early_count", q_data.size(), 169);
    check_plane("after_early", 0, 0, 0, 169, 168);
    check("early_err_sticky", 32'(frame_err), 1);

    // Reset after 300 accepted pixels, then a full plane
    send_plane(0, 0, 300, -1);
    do_reset();
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_frame_err", 32'(frame_err), 0);
    send_plane(0, 0, 729, 728);
    idle(20);
    check("midrst_count", q_data.size(), 169);
    check_plane("midrst", 0, 0, 0, 169, 168);

    // Two planes back-to-back, second offset by 1000
    q_data.delete(); q_last.delete(); q_cyc.delete();
    send_plane(0, 0, 729, 728);
    send_plane(0, 1000, 729, 728);
    idle(20);
    check("b2b_count", q_data.size(), 338);
    check_plane("b2b_p1", 0, 0, 0, 169, 168);
    check_plane("b2b_p2", 0, 1000, 169, 169, 168);
    if (q_data.size() >= 338) begin
      check("b2b_p2_first", q_data[169], 1056);
      check("b2b_p2_final", q_data[337], 1728);
      check("b2b_gap", q_cyc[169] - q_cyc[168], 57);
    end
    check("b2b_frame_err", 32'(frame_err), 0);

    // Final pixel without in_last: outputs kept, error flagged
    q_data.delete(); q_last.delete(); q_cyc.delete();
    send_plane(0, 0, 729, -1);
    idle(20);
    check("nolast_count", q_data.size(), 169);
    check_plane("nolast", 0, 0, 0, 169, 168);
    check("nolast_frame_err", 32'(frame_err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
